// File: rtl/swd_rot_ise.sv
// swd_rot_ise: shift/rotate ISE unit for the 8-bit core.
//
// Holds an NBYTES-wide word that the core loads two bytes per ISE instruction,
// applies rotate-left/right or logical shift-left/right by a variable amount,
// then hands the result back one byte per instruction, MSB first. Carry and
// zero flags from the operation are merged into the status register while the
// result is being unloaded.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start    in   ISE instruction strobe
//   a        in   load: low byte of pair; shift: amount (low SHW bits)
//   b        in   load: high byte of pair; shift: mode (low 2 bits)
//   sr       in   core status register
//   sr_out   out  status register back to the core (flags merged in UNLOAD)
//   result   out  registered result byte
//   wait_req out  stall request (shift-start cycle and execute cycle)
module swd_rot_ise #(
   parameter int unsigned NBYTES = 4,
   parameter int unsigned C_BIT  = 0,
   parameter int unsigned Z_BIT  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] sr,
   output logic [7:0] sr_out,
   output logic [7:0] result,
   output logic       wait_req
);

   localparam int unsigned W     = 8 * NBYTES;
   localparam int unsigned SHW   = $clog2(W);
   localparam int unsigned NPAIR = NBYTES / 2;
   localparam int unsigned PIW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
   localparam int unsigned BIW   = $clog2(NBYTES);

   localparam logic [PIW-1:0] LAST_PAIR = PIW'(NPAIR - 1);
   localparam logic [BIW-1:0] LAST_BYTE = BIW'(NBYTES - 1);
   localparam logic [BIW-1:0] BYTE_ONE  = BIW'(1);
   localparam logic [SHW-1:0] AMT_ONE   = SHW'(1);

   typedef enum logic [1:0] {StLoad, StShift, StExec, StUnload} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [W-1:0]   r_word;
   logic [SHW-1:0] r_amt;
   logic [1:0]     r_mode;
   logic [PIW-1:0] r_pair_idx;
   logic [BIW-1:0] r_byte_idx;
   logic [7:0]     r_result;
   logic           r_c;
   logic           r_z;

   logic [2*W-1:0] w_dbl_l;
   logic [2*W-1:0] w_dbl_r;
   logic [W-1:0]   w_new;
   logic           w_carry;
   logic [SHW-1:0] w_neg_amt;
   logic [BIW-1:0] w_prev_idx;
   logic [7:0]     w_prev_byte;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StLoad;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      wait_req    = 1'b0;
      case (r_state)
         StLoad: begin
            if (start && (r_pair_idx == LAST_PAIR)) begin
               w_state_nxt = StShift;
            end
         end
         StShift: begin
            if (start) begin
               wait_req    = 1'b1;
               w_state_nxt = StExec;
            end
         end
         StExec: begin
            wait_req    = 1'b1;
            w_state_nxt = StUnload;
         end
         StUnload: begin
            if (start && (r_byte_idx == '0)) begin
               w_state_nxt = StLoad;
            end
         end
         default: w_state_nxt = StLoad;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Shifter: rotates come from the word concatenated with itself
   // ---------------------------------------------------------------------------
   assign w_dbl_l   = {r_word, r_word} << r_amt;
   assign w_dbl_r   = {r_word, r_word} >> r_amt;
   // W - amt reduced to SHW bits; only used when amt != 0
   assign w_neg_amt = '0 - r_amt;

   always_comb begin
      w_new   = r_word;
      w_carry = 1'b0;
      case (r_mode)
         2'b00:   w_new = w_dbl_l[2*W-1:W];
         2'b01:   w_new = w_dbl_r[W-1:0];
         2'b10:   w_new = r_word << r_amt;
         default: w_new = r_word >> r_amt;
      endcase
      if (r_amt != '0) begin
         case (r_mode)
            2'b00:   w_carry = w_new[0];
            2'b01:   w_carry = w_new[W-1];
            2'b10:   w_carry = r_word[w_neg_amt];
            default: w_carry = r_word[r_amt - AMT_ONE];
         endcase
      end
   end

   // Next byte to present while unloading
   assign w_prev_idx = r_byte_idx - BYTE_ONE;

   always_comb begin
      w_prev_byte = 8'h00;
      for (int unsigned i = 0; i < NBYTES; i++) begin
         if (w_prev_idx == BIW'(i)) begin
            w_prev_byte = r_word[8*i +: 8];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word     <= '0;
         r_amt      <= '0;
         r_mode     <= '0;
         r_pair_idx <= '0;
         r_byte_idx <= LAST_BYTE;
         r_result   <= '0;
         r_c        <= 1'b0;
         r_z        <= 1'b0;
      end else begin
         case (r_state)
            StLoad: begin
               if (start) begin
                  for (int unsigned p = 0; p < NPAIR; p++) begin
                     if (r_pair_idx == PIW'(p)) begin
                        r_word[16*p +: 16] <= {b, a};
                     end
                  end
                  if (r_pair_idx == LAST_PAIR) begin
                     r_pair_idx <= '0;
                  end else begin
                     r_pair_idx <= r_pair_idx + PIW'(1);
                  end
               end
            end
            StShift: begin
               if (start) begin
                  r_amt  <= a[SHW-1:0];
                  r_mode <= b[1:0];
               end
            end
            StExec: begin
               r_word     <= w_new;
               r_result   <= w_new[W-1:W-8];
               r_c        <= w_carry;
               r_z        <= (w_new == '0);
               r_byte_idx <= LAST_BYTE;
            end
            StUnload: begin
               // With byte_idx = 0 the last start just returns to LOAD
               if (start && (r_byte_idx != '0)) begin
                  r_result   <= w_prev_byte;
                  r_byte_idx <= w_prev_idx;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign result = r_result;

   always_comb begin
      sr_out = sr;
      if (r_state == StUnload) begin
         sr_out[C_BIT] = r_c;
         sr_out[Z_BIT] = r_z;
      end
   end

endmodule

// File: tb/tb_swd_rot_ise.sv
module tb_swd_rot_ise;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] sr;
   logic [7:0] sr_out4, result4, sr_out2, result2;
   logic       wait4, wait2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   swd_rot_ise #(.NBYTES(4)) u_dut4 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .sr       (sr),
      .sr_out   (sr_out4),
      .result   (result4),
      .wait_req (wait4)
   );

   swd_rot_ise #(.NBYTES(2)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .sr       (sr),
      .sr_out   (sr_out2),
      .result   (result2),
      .wait_req (wait2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int nb, output logic [7:0] res, output logic wr,
                         output logic [7:0] so);
      if (nb == 2) begin
         res = result2; wr = wait2; so = sr_out2;
      end else begin
         res = result4; wr = wait4; so = sr_out4;
      end
   endtask

   // Reference: operate on w-bit word bit by bit
   function automatic logic [127:0] ref_f(input logic [127:0] old, input int w, input int amt,
                                          input int mode, output logic c);
      logic [127:0] n;
      n = '0;
      for (int i = 0; i < w; i++) begin
         case (mode)
            0: n[(i + amt) % w] = old[i];
            1: n[i] = old[(i + amt) % w];
            2: if (i >= amt) n[i] = old[i - amt];
            default: if (i + amt < w) n[i] = old[i + amt];
         endcase
      end
      if (amt == 0) c = 1'b0;
      else begin
         case (mode)
            0: c = n[0];
            1: c = n[w-1];
            2: c = old[w-amt];
            default: c = old[amt-1];
         endcase
      end
      return n;
   endfunction

   // Full load/shift/unload sequence. abort_at: -1 none, 0 during EXEC,
   // k>0 after k unloaded bytes.
   task automatic run_op(input int nb, input logic [127:0] word, input logic [7:0] sa,
                         input logic [7:0] sb, input bit hold, input int abort_at,
                         input string name);
      int           w;
      int           amt;
      int           mode;
      logic [127:0] exp;
      logic         c;
      logic         z;
      logic [7:0]   res, so, exp_sr, exp_byte;
      logic         wr;
      bit           aborted;
      w       = 8 * nb;
      amt     = int'(sa) & (w - 1);
      mode    = int'(sb) & 3;
      exp     = ref_f(word, w, amt, mode, c);
      z       = (exp == '0);
      aborted = 1'b0;

      for (int p = 0; p < nb / 2; p++) begin
         start = 1'b1;
         a     = word[16*p +: 8];
         b     = word[16*p+8 +: 8];
         sr    = 8'($urandom);
         #1;
         sample(nb, res, wr, so);
         total_cnt++;
         if (wr !== 1'b0 || so !== sr)
            $display("FAIL %s load: wait_req=%b sr_out=%h, want 0 and %h", name, wr, so, sr);
         else pass_cnt++;
         step();
      end

      start = 1'b1;
      a     = sa;
      b     = sb;
      sr    = 8'($urandom);
      #1;
      sample(nb, res, wr, so);
      total_cnt++;
      if (wr !== 1'b1) $display("FAIL %s shift_wait: wait_req=%b, want 1", name, wr);
      else pass_cnt++;
      step();

      start = hold;
      a     = 8'($urandom);
      b     = 8'($urandom);
      sr    = 8'($urandom);
      #1;
      sample(nb, res, wr, so);
      total_cnt++;
      if (wr !== 1'b1 || so !== sr)
         $display("FAIL %s exec: wait_req=%b sr_out=%h, want 1 and %h", name, wr, so, sr);
      else pass_cnt++;

      if (abort_at == 0) aborted = 1'b1;
      else begin
         step();
         for (int k = 0; k < nb; k++) begin
            exp_byte = exp[8*(nb-1-k) +: 8];
            if (abort_at == k) begin
               aborted = 1'b1;
               break;
            end
            if (!hold && (k % 2 == 0)) begin
               start = 1'b0;
               sr    = 8'($urandom);
               #1;
               sample(nb, res, wr, so);
               total_cnt++;
               if (res !== exp_byte)
                  $display("FAIL %s idle_byte%0d: result=%h, want %h", name, k, res, exp_byte);
               else pass_cnt++;
               step();
            end
            start     = 1'b1;
            a         = 8'($urandom);
            b         = 8'($urandom);
            sr        = 8'($urandom);
            exp_sr    = sr;
            exp_sr[0] = c;
            exp_sr[1] = z;
            #1;
            sample(nb, res, wr, so);
            total_cnt++;
            if (res !== exp_byte || wr !== 1'b0 || so !== exp_sr)
               $display("FAIL %s byte%0d: result=%h wait=%b sr_out=%h, want %h 0 %h",
                        name, k, res, wr, so, exp_byte, exp_sr);
            else pass_cnt++;
            step();
         end
      end

      if (aborted) begin
         rst   = 1'b1;
         start = 1'b0;
         step();
         rst = 1'b0;
         sr  = 8'($urandom);
         #1;
         sample(nb, res, wr, so);
         total_cnt++;
         if (res !== 8'h00 || wr !== 1'b0 || so !== sr)
            $display("FAIL %s abort: result=%h wait=%b sr_out=%h, want 00 0 %h",
                     name, res, wr, so, sr);
         else pass_cnt++;
      end else begin
         // Back in LOAD: last byte held, flags no longer merged
         start = 1'b0;
         sr    = 8'($urandom);
         #1;
         sample(nb, res, wr, so);
         total_cnt++;
         if (res !== exp[7:0] || wr !== 1'b0 || so !== sr)
            $display("FAIL %s done: result=%h wait=%b sr_out=%h, want %h 0 %h",
                     name, res, wr, so, exp[7:0], sr);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      sr    = 8'h00;
      step();
      step();
      rst = 1'b0;
      sr  = 8'hA5;
      #1;
      total_cnt++;
      if (result4 !== 8'h00 || wait4 !== 1'b0 || sr_out4 !== 8'hA5)
         $display("FAIL reset4: result=%h wait=%b sr_out=%h, want 00 0 a5",
                  result4, wait4, sr_out4);
      else pass_cnt++;
      total_cnt++;
      if (result2 !== 8'h00 || wait2 !== 1'b0 || sr_out2 !== 8'hA5)
         $display("FAIL reset2: result=%h wait=%b sr_out=%h, want 00 0 a5",
                  result2, wait2, sr_out2);
      else pass_cnt++;
   endtask

   task automatic test_directed();
      run_op(4, 128'h44332211, 8'h08, 8'h00, 1'b0, -1, "rotl8");
      run_op(4, 128'h44332211, 8'h04, 8'h01, 1'b0, -1, "rotr4");
      run_op(4, 128'h44332211, 8'h01, 8'h03, 1'b0, -1, "shr1");
      run_op(4, 128'h00000002, 8'd31, 8'h02, 1'b0, -1, "shl31");
      run_op(4, 128'h44332211, 8'h24, 8'h02, 1'b0, -1, "shl_trunc");
      run_op(4, 128'h80000001, 8'h00, 8'h03, 1'b0, -1, "amt0");
   endtask

   task automatic test_abort();
      run_op(4, 128'h44332211, 8'h08, 8'h00, 1'b0, 0, "abort_exec");
      run_op(4, 128'hDEADBEEF, 8'h05, 8'h01, 1'b0, -1, "after_abort_exec");
      run_op(4, 128'h44332211, 8'h08, 8'h00, 1'b0, 2, "abort_unload");
      run_op(4, 128'h0F0F1234, 8'h0C, 8'h00, 1'b0, -1, "after_abort_unload");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op(4, {96'h0, 32'($urandom)}, 8'($urandom), 8'(i), 1'b1, -1, "hold");
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         run_op(4, {96'h0, 32'($urandom)}, 8'($urandom), 8'($urandom), 1'b0, -1, "rand4");
      end
   endtask

   task automatic test_nbytes2();
      rst   = 1'b1;
      start = 1'b0;
      step();
      rst = 1'b0;
      run_op(2, 128'hABCD, 8'h14, 8'h00, 1'b0, -1, "n2_rotl4");
      for (int i = 0; i < 8; i++) begin
         run_op(2, {112'h0, 16'($urandom)}, 8'($urandom), 8'($urandom), i[0], -1, "rand2");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_back_to_back();
      test_random();
      test_nbytes2();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
